// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback front end.
package writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // Decode a register index into a one-hot register mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Producer/consumer bundle around the register file write port.
// master: pipeline, long-latency unit and hazard logic; slave: the arbiter.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;

  logic                  pipe_we_i;
  logic [REG_ADDR_W-1:0] pipe_addr_i;
  logic [REG_DATA_W-1:0] pipe_data_i;

  logic                  lu_valid_i;
  logic                  lu_ready_o;
  logic [REG_ADDR_W-1:0] lu_addr_i;
  logic [REG_DATA_W-1:0] lu_data_i;

  logic [REG_ADDR_W-1:0] RDaddr_o;
  logic [REG_DATA_W-1:0] RDdata_o;
  logic                  RegWrite_o;

  logic                  stall_o;
  logic [NUM_REGS-1:0]   pending_o;

  modport master (
    output pipe_we_i, pipe_addr_i, pipe_data_i,
    output lu_valid_i, lu_addr_i, lu_data_i,
    input  lu_ready_o,
    input  RDaddr_o, RDdata_o, RegWrite_o,
    input  stall_o, pending_o
  );

  modport slave (
    input  pipe_we_i, pipe_addr_i, pipe_data_i,
    input  lu_valid_i, lu_addr_i, lu_data_i,
    output lu_ready_o,
    output RDaddr_o, RDdata_o, RegWrite_o,
    output stall_o, pending_o
  );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Long-latency result queue. Per-entry valid and address taps feed the
// pending-write mask so hazard logic sees exactly what is still queued.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            push_i,
  input  wb_req_t                         push_req_i,
  input  logic                            pop_i,
  output wb_req_t                         head_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic [DEPTH-1:0]                valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_o
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;

  // Address taps for the pending mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_o[i] = mem_q[i].addr;
    end
  end

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q]   = push_req_i;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem_q    <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register file write-port arbiter: the pipeline writeback always wins,
// long-latency results queue and drain into idle slots, and a starved
// queue head forces a one-cycle pipeline bubble.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input logic               clk_i,
  input logic               rst_n_i,
  writeback_arbiter_if.slave wb
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  wb_req_t                          fifo_head;
  wb_req_t                          fifo_push_req;
  logic                             fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]           fifo_count;
  logic [DEPTH-1:0]                 fifo_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] fifo_addr;
  logic                             fifo_push, fifo_pop;

  logic                  pipe_busy;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [REG_DATA_W-1:0] rd_data;
  logic                  reg_write;
  logic [NUM_REGS-1:0]   pending;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                stall_q, stall_d;

  assign fifo_push_req = '{addr: wb.lu_addr_i, data: wb.lu_data_i};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (fifo_push),
    .push_req_i (fifo_push_req),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .valid_o    (fifo_valid),
    .addr_o     (fifo_addr)
  );

  // Write-port select; a write to $0 never occupies the slot.
  always_comb begin
    pipe_busy = wb.pipe_we_i && (wb.pipe_addr_i != '0);
    lu_ready  = rst_n_i && !fifo_full;
    fifo_push = wb.lu_valid_i && lu_ready && (wb.lu_addr_i != '0);
    fifo_pop  = !pipe_busy && !fifo_empty;
    rd_addr   = '0;
    rd_data   = '0;
    reg_write = 1'b0;
    if (pipe_busy) begin
      rd_addr   = wb.pipe_addr_i;
      rd_data   = wb.pipe_data_i;
      reg_write = 1'b1;
    end else if (!fifo_empty) begin
      rd_addr   = fifo_head.addr;
      rd_data   = fifo_head.data;
      reg_write = 1'b1;
    end
    if (!rst_n_i) begin
      reg_write = 1'b0;
    end
  end

  // Pending mask reflects queued entries only, never the incoming offer.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) begin
        pending = pending | reg_onehot(fifo_addr[i]);
      end
    end
  end

  // Starvation count saturates so a pipeline that ignores the bubble keeps
  // seeing stall until the head finally drains.
  always_comb begin
    starve_d = starve_q;
    if (fifo_count == '0 || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    stall_d = (starve_d == STARVE_W'(STARVE_MAX));
  end

  // Starvation counter and stall request registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign wb.lu_ready_o = lu_ready;
  assign wb.RDaddr_o   = rd_addr;
  assign wb.RDdata_o   = rd_data;
  assign wb.RegWrite_o = reg_write;
  assign wb.stall_o    = stall_q;
  assign wb.pending_o  = pending;

endmodule
